// File: rtl/fifo_pop_ctrl.sv
// Pop controller: drains an upstream FIFO with one-cycle read latency
// into a 2-entry holding buffer behind a valid/ready output.
module fifo_pop_ctrl #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [7:0]            out_count,
    output logic                  busy
);

    localparam int HOLD_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [1:0]            hold_cnt;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic                  inflight;
    logic [7:0]            cnt_q;
    logic [DATA_WIDTH-1:0] hold_mem [HOLD_DEPTH];

    logic       xfer;
    logic       capture;
    logic [2:0] pending;

    assign out_valid = (hold_cnt != 2'd0);
    assign xfer      = out_valid && out_ready;
    assign capture   = inflight;

    // Slots that will be occupied next cycle; a pop is safe only if one stays free.
    assign pending = {1'b0, hold_cnt}
                   + {2'b00, inflight}
                   - {2'b00, xfer};

    assign fifo_rd_en = (state_q == STREAM)
                     && !fifo_empty
                     && (pending < 3'd2);

    assign out_data  = hold_mem[rd_ptr];
    assign out_count = cnt_q;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (!enable) begin
                    if ((hold_cnt != 2'd0) || inflight) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_d = STREAM;
                end else if ((hold_cnt == 2'd0) && !inflight) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            inflight <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            inflight <= fifo_rd_en;
            if (capture) begin
                wr_ptr <= ~wr_ptr;
            end
            if (xfer) begin
                rd_ptr <= ~rd_ptr;
                cnt_q  <= cnt_q + 8'd1;
            end
            unique case (1'b1)
                capture && !xfer: hold_cnt <= hold_cnt + 2'd1;
                xfer && !capture: hold_cnt <= hold_cnt - 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HOLD_DEPTH; i++) begin
                hold_mem[i] <= '0;
            end
        end else if (capture) begin
            hold_mem[wr_ptr] <= fifo_data;
        end
    end

endmodule

// File: doc/fifo_pop_ctrl.md
FIFO_POP_CTRL -- requirements
Module: fifo_pop_ctrl

Interface
REQ-001 Parameter DATA_WIDTH: default 4; width of one FIFO word.
REQ-002 Parameter HOLD_DEPTH: fixed at 2; entries in the internal holding buffer; not overridable.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  high permits popping the upstream FIFO.
REQ-006 fifo_empty  input  1  empty flag from the upstream FIFO.
REQ-007 fifo_data  input  DATA_WIDTH  upstream FIFO output word, valid the cycle after a pop.
REQ-008 fifo_rd_en  output  1  pop strobe to the upstream FIFO.
REQ-009 out_ready  input  1  downstream consumer accepts out_data this cycle.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_data  output  DATA_WIDTH  word presented downstream.
REQ-012 out_count  output  8  number of words delivered downstream, modulo 256.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 FSM states SHALL be IDLE, STREAM, DRAIN, state-encoded in a registered variable.
REQ-015 IDLE->STREAM when enable=1; STREAM->DRAIN when enable=0 and (hold_cnt!=0 or inflight=1); STREAM->IDLE when enable=0 and nothing outstanding; DRAIN->IDLE when hold_cnt=0 and inflight=0; DRAIN->STREAM when enable=1.
REQ-016 fifo_rd_en SHALL be combinational: state==STREAM and !fifo_empty and (hold_cnt + inflight - (out_valid && out_ready)) < 2.
REQ-017 inflight SHALL be a register equal to fifo_rd_en of the previous cycle.
REQ-018 When inflight=1, fifo_data SHALL be written into the holding buffer at the next posedge (one-cycle pop latency).
REQ-019 out_valid SHALL be high exactly when hold_cnt!=0; out_data SHALL be the oldest held word.
REQ-020 A transfer occurs when out_valid && out_ready; the head word is removed at that posedge.
REQ-021 Simultaneous capture and transfer in one cycle SHALL leave hold_cnt unchanged and preserve order.
REQ-022 Holding buffer SHALL be a 2-entry circular buffer with 1-bit read/write pointers that wrap 1->0.
REQ-023 hold_cnt SHALL never exceed 2; no word SHALL be dropped or duplicated.
REQ-024 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 out_count SHALL increment by 1 per transfer and wrap 255->0.
REQ-026 In DRAIN no new pops SHALL issue; outstanding words SHALL still be captured and delivered.
REQ-027 With out_ready held high and FIFO non-empty, sustained throughput SHALL be one word per cycle.
REQ-028 First out_valid SHALL occur 2 cycles after enable is sampled high in IDLE with a non-empty FIFO.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, hold_cnt=0, pointers=0, inflight=0, out_count=0, out_data=0.
REQ-030 During reset, fifo_rd_en=0, out_valid=0, busy=0.
REQ-031 Reset mid-operation SHALL discard held and in-flight words; no partial transfer after release.
REQ-032 After rst_n rises, first pop SHALL not issue before the first posedge at which enable=1 is sampled.

Verification
REQ-033 FIFO preloaded with 3,7,9,A, out_ready=1, enable pulsed high -> out_data 3,7,9,A on 4 consecutive cycles, out_count=4, busy falls once FIFO empties and enable drops.
REQ-034 out_ready=0 with 5 words queued, enable=1 -> exactly 2 pops issued, fifo_rd_en then 0, out_data=first word stable; out_ready=1 -> remaining words in order.
REQ-035 enable dropped while hold_cnt=2 -> state DRAIN, fifo_rd_en=0, both words delivered, then IDLE.
REQ-036 Deliver 257 words -> out_count wraps to 1.
REQ-037 rst_n low while hold_cnt=2 and inflight=1 -> out_valid=0, out_count=0 immediately; after release, no stale word ever appears.
REQ-038 fifo_empty=1 in STREAM -> fifo_rd_en never asserts; FIFO fills with one word -> pop next cycle, out_valid one cycle later.
